epd_scan: RTL and testbench

EPD_SCAN -- requirements
Module: epd_scan

---
 rtl/epd_scan_if.sv | 23 ++
 rtl/epd_scan.sv | 190 +++++++++++++++++++
 tb/tb_epd_scan.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epd_scan_if.sv
// epd_scan_if: frame-buffer memory side of the EPD scan controller.
// The memory interface (master) supplies 64-bit pixel words with a
// valid/ready handshake; epd_scan (slave) requests each frame with vsync.
interface epd_scan_if;
  logic        vsync;
  logic [63:0] pix_read;
  logic        pix_read_valid;
  logic        pix_read_ready;

  modport master (
    output pix_read,
    output pix_read_valid,
    input  pix_read_ready,
    input  vsync
  );

  modport slave (
    input  pix_read,
    input  pix_read_valid,
    output pix_read_ready,
    output vsync
  );
endinterface

// File: rtl/epd_scan.sv
// epd_scan: e-paper panel scan controller. Per frame it pulses the gate
// start sequence, then for every gate line streams H_WORDS 64-bit words to
// the source driver as 16-bit beats, latches the line and clocks the gate.
// Optional feature: define EPD_SCAN_BEAT_SWAP_EN to emit the beats of each
// word most-significant first.
module epd_scan #(
  parameter int H_WORDS = 50,
  parameter int V_LINES = 1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  epd_scan_if.slave   mem,
  output logic        epd_gdoe,
  output logic        epd_gdclk,
  output logic        epd_gdsp,
  output logic        epd_sdclk,
  output logic        epd_sdle,
  output logic        epd_sdoe,
  output logic        epd_sdce0,
  output logic [15:0] epd_sd,
  output logic        frame_done,
  output logic        underrun
);

  localparam int WW = $clog2(H_WORDS + 1);
  localparam int LW = $clog2(V_LINES + 1);

  typedef enum logic [2:0] {
    IDLE, VSTART, LINE_DATA, LINE_LATCH, LINE_GATE, FRAME_END
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cyc_q;       // cycle index inside VSTART / LINE_LATCH / LINE_GATE
  logic            phase_q;     // beat phase: 0 = data update, 1 = sdclk high
  logic [1:0]      beat_q;      // beat index within the current word
  logic [WW-1:0]   wcnt_q;      // words emitted on the current line
  logic [LW-1:0]   lcnt_q;      // gate line being scanned
  logic [WW-1:0]   fword_q;     // words fetched for the line being fetched
  logic [LW-1:0]   fline_q;     // lines completely fetched this frame
  logic            buf_full_q;
  logic [63:0]     buf_q;       // holds the word until its last beat is sent
  logic [15:0]     sd_q;        // last driven beat, held during stalls
  logic            underrun_q;

  logic            stall, emptying, line_end, accept;
  logic [1:0]      beat_sel;

  // Next state, handshake and panel outputs decoded from the current state.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d            = state_q;
    stall              = 1'b0;
    emptying           = 1'b0;
    line_end           = 1'b0;
    mem.vsync          = 1'b0;
    epd_gdoe           = 1'b0;
    epd_gdclk          = 1'b0;
    epd_gdsp           = 1'b0;
    epd_sdclk          = 1'b0;
    epd_sdle           = 1'b0;
    epd_sdoe           = 1'b0;
    epd_sdce0          = 1'b1;
    frame_done         = 1'b0;
    epd_sd             = sd_q;
    beat_sel           = beat_q;
`ifdef EPD_SCAN_BEAT_SWAP_EN
    beat_sel           = ~beat_q;
`endif

    if (state_q == LINE_DATA) begin
      stall     = !buf_full_q;
      emptying  = buf_full_q && phase_q && (beat_q == 2'd3);
      line_end  = emptying && (wcnt_q == WW'(H_WORDS - 1));
      epd_gdoe  = 1'b1;
      epd_sdce0 = 1'b0;
      epd_sdoe  = 1'b1;
      epd_sdclk = buf_full_q && phase_q;
      if (buf_full_q) epd_sd = buf_q[{beat_sel, 4'h0} +: 16];
    end

    // The next word may arrive in the last cycle of the current one; the
    // fetch side runs one word ahead of the scan, across line boundaries.
    mem.pix_read_ready = ((state_q == VSTART) || (state_q == LINE_DATA)) &&
                         (!buf_full_q || emptying) &&
                         (fline_q < LW'(V_LINES));
    accept = mem.pix_read_valid && mem.pix_read_ready;

    case (state_q)
      IDLE: begin
        if (en) begin
          mem.vsync = 1'b1;
          state_d   = VSTART;
        end
      end
      VSTART: begin
        epd_gdsp  = 1'b1;
        epd_gdclk = (cyc_q == 2'd1) || (cyc_q == 2'd2);
        if (cyc_q == 2'd3) state_d = LINE_DATA;
      end
      LINE_DATA: begin
        if (line_end) state_d = LINE_LATCH;
      end
      LINE_LATCH: begin
        epd_gdoe = 1'b1;
        epd_sdle = 1'b1;
        epd_sdoe = 1'b1;
        if (cyc_q == 2'd1) state_d = LINE_GATE;
      end
      LINE_GATE: begin
        epd_gdoe  = 1'b1;
        epd_gdclk = (cyc_q == 2'd1) || (cyc_q == 2'd2);
        if (cyc_q == 2'd3)
          state_d = (lcnt_q == LW'(V_LINES - 1)) ? FRAME_END : LINE_DATA;
      end
      FRAME_END: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, counters, prefetch flag and sticky underrun.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      phase_q    <= 1'b0;
      beat_q     <= '0;
      wcnt_q     <= '0;
      lcnt_q     <= '0;
      fword_q    <= '0;
      fline_q    <= '0;
      buf_full_q <= 1'b0;
      sd_q       <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= (state_d != state_q) ? 2'd0 : cyc_q + 2'd1;
      sd_q    <= epd_sd;

      if (accept)        buf_full_q <= 1'b1;
      else if (emptying) buf_full_q <= 1'b0;

      if (stall) underrun_q <= 1'b1;

      if (state_q != LINE_DATA) begin
        phase_q <= 1'b0;
        beat_q  <= '0;
        wcnt_q  <= '0;
      end else if (!stall) begin
        phase_q <= !phase_q;
        if (phase_q) begin
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'd3) wcnt_q <= wcnt_q + WW'(1);
        end
      end

      if (state_q == VSTART)
        lcnt_q <= '0;
      else if ((state_q == LINE_GATE) && (cyc_q == 2'd3))
        lcnt_q <= lcnt_q + LW'(1);

      if (state_q == IDLE) begin
        fword_q <= '0;
        fline_q <= '0;
      end else if (accept) begin
        if (fword_q == WW'(H_WORDS - 1)) begin
          fword_q <= '0;
          fline_q <= fline_q + LW'(1);
        end else begin
          fword_q <= fword_q + WW'(1);
        end
      end
    end
  end

  // Prefetch data register.
  // NOTE: the data word is not reset; buf_full_q qualifies every use of it.
  always_ff @(posedge clk) begin
    if (accept) buf_q <= mem.pix_read;
  end

  assign underrun = underrun_q;

endmodule

// File: tb/tb_epd_scan.sv
// tb_epd_scan: randomized scoreboard bench for epd_scan with a small panel
// (2 words per line, 3 lines). A driver feeds words and queues the beats
// each accepted word must produce; a monitor pops them on every sdclk high
// and checks per-frame timing and pulse counts at frame_done.
module tb_epd_scan;
  localparam int H = 2;
  localparam int V = 3;
  localparam int LINE_CYCLES = 8 * H + 6;
  localparam int FRAME_LEN   = 1 + 4 + V * LINE_CYCLES;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        epd_gdoe, epd_gdclk, epd_gdsp;
  logic        epd_sdclk, epd_sdle, epd_sdoe, epd_sdce0;
  logic [15:0] epd_sd;
  logic        frame_done, underrun;

  epd_scan_if mem ();

  epd_scan #(.H_WORDS(H), .V_LINES(V)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mem        (mem),
    .epd_gdoe   (epd_gdoe),
    .epd_gdclk  (epd_gdclk),
    .epd_gdsp   (epd_gdsp),
    .epd_sdclk  (epd_sdclk),
    .epd_sdle   (epd_sdle),
    .epd_sdoe   (epd_sdoe),
    .epd_sdce0  (epd_sdce0),
    .epd_sd     (epd_sd),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sb[$];          // expected beats, oldest first
  logic [16:0] trace[$];       // {sdclk, sd} for the first LINE_DATA cycles of the run

  // Driver controls
  bit fixed_pending = 1'b1;    // first word of the run is the known pattern
  bit rand_valid    = 1'b0;
  bit drop_arm      = 1'b0;
  int drop_left     = 0;
  int acc_total     = 0;
  int exp_stall     = 0;       // stall cycles expected in this frame, -1 = unknown

  // Monitor state
  int cyc = 0, vsync_cyc = 0, vsync_cnt = 0, done_cnt = 0;
  int sdle_n = 0, gdclk_n = 0, gdsp_n = 0, gdoe_n = 0;
  int lines_in_frame = 0, acc_at_vsync = 0;
  bit prev_sdle = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the source driver: the four 16-bit beats of a word in
  // the order the panel must receive them.
  function automatic void push_word(input logic [63:0] w);
    for (int b = 0; b < 4; b++) begin
`ifdef EPD_SCAN_BEAT_SWAP_EN
      sb.push_back(w[16 * (3 - b) +: 16]);
`else
      sb.push_back(w[16 * b +: 16]);
`endif
    end
  endfunction

  // Driver: presents words, optionally throttles valid, records accepted words.
  initial begin : driver
    bit need_word;
    need_word = 1'b1;
    mem.pix_read       = '0;
    mem.pix_read_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (need_word) begin
        if (fixed_pending) begin
          mem.pix_read  = 64'h4444_3333_2222_1111;
          fixed_pending = 1'b0;
        end else begin
          mem.pix_read = {$urandom, $urandom};
        end
        need_word = 1'b0;
      end
      #1;
      if (drop_left > 0) begin
        mem.pix_read_valid = 1'b0;
        drop_left--;
      end else if (drop_arm && mem.pix_read_ready && !epd_sdce0) begin
        mem.pix_read_valid = 1'b0;
        drop_arm  = 1'b0;
        drop_left = 4;
      end else if (rand_valid) begin
        mem.pix_read_valid = ($urandom_range(0, 3) != 0);
      end else begin
        mem.pix_read_valid = 1'b1;
      end
      if (mem.pix_read_valid && mem.pix_read_ready) begin
        push_word(mem.pix_read);
        acc_total++;
        need_word = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops on sdclk high, frame checks on frame_done.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (mem.vsync) begin
        vsync_cnt++;
        vsync_cyc      = cyc;
        sdle_n         = 0;
        gdclk_n        = 0;
        gdsp_n         = 0;
        gdoe_n         = 0;
        lines_in_frame = 0;
        acc_at_vsync   = acc_total;
      end
      sdle_n  += int'(epd_sdle);
      gdclk_n += int'(epd_gdclk);
      gdsp_n  += int'(epd_gdsp);
      gdoe_n  += int'(epd_gdoe);
      if (epd_sdle && !prev_sdle) lines_in_frame++;
      prev_sdle = epd_sdle;
      if (!epd_sdce0 && trace.size() < 8) trace.push_back({epd_sdclk, epd_sd});
      if (epd_sdclk) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected: got %0h expected no beat (t=%0t)", epd_sd, $time);
        end else begin
          check("beat_data", epd_sd, sb.pop_front());
        end
      end
      if (frame_done) begin
        done_cnt++;
        if (exp_stall >= 0) begin
          check("frame_len", cyc - vsync_cyc, FRAME_LEN + exp_stall);
          check("gdoe_cycles", gdoe_n, V * LINE_CYCLES + exp_stall);
        end
        check("sdle_cycles", sdle_n, 2 * V);
        check("gdclk_cycles", gdclk_n, 2 + 2 * V);
        check("gdsp_cycles", gdsp_n, 4);
        check("words_accepted", acc_total - acc_at_vsync, H * V);
        check("scoreboard_drained", sb.size(), 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vsync"},      mem.vsync, 0);
    check({tag, "_ready"},      mem.pix_read_ready, 0);
    check({tag, "_gdoe"},       epd_gdoe, 0);
    check({tag, "_gdclk"},      epd_gdclk, 0);
    check({tag, "_gdsp"},       epd_gdsp, 0);
    check({tag, "_sdclk"},      epd_sdclk, 0);
    check({tag, "_sdle"},       epd_sdle, 0);
    check({tag, "_sdoe"},       epd_sdoe, 0);
    check({tag, "_sdce0"},      epd_sdce0, 1);
    check({tag, "_sd"},         epd_sd, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_underrun"},   underrun, 0);
  endtask

  // Raise en, hold it until line 0 is being scanned, then drop it.
  task automatic start_frame();
    int n;
    n = 0;
    @(negedge clk);
    en = 1'b1;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (epd_sdce0 && n < 50);
    check("line0_reached", epd_sdce0, 0);
    en = 1'b0;
  endtask

  task automatic wait_line1();
    int n;
    n = 0;
    while (!(lines_in_frame == 1 && !epd_sdce0) && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("line1_timeout", int'(n >= 200), 0);
  endtask

  task automatic wait_done(input int budget);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("frame_done_count", done_cnt - start, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int done_before, vs_before;
    logic [15:0] exp_sd;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Frame A: continuous data, en dropped during line 0, known first word.
    exp_stall = 0;
    start_frame();
    wait_done(400);
    check("underrun_clean", underrun, 0);
    repeat (20) @(negedge clk);
    #3;
    check("single_vsync", vsync_cnt, 1);
    check("single_done", done_cnt, 1);
    check("trace_len", trace.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < trace.size()) begin
`ifdef EPD_SCAN_BEAT_SWAP_EN
        exp_sd = 16'(16'h1111 * (4 - i / 2));
`else
        exp_sd = 16'(16'h1111 * (i / 2 + 1));
`endif
        check("first_word_sd", trace[i][15:0], exp_sd);
        check("first_word_sdclk", trace[i][16], i % 2);
      end
    end

    // Frame B: valid withdrawn for 5 cycles in the middle of line 1.
    exp_stall = 5;
    start_frame();
    wait_line1();
    drop_arm = 1'b1;
    wait_done(400);
    check("underrun_set", underrun, 1);
    repeat (5) @(negedge clk);
    #3;
    check("underrun_sticky", underrun, 1);

    // Frames C, D: random valid pattern and random data.
    exp_stall  = -1;
    rand_valid = 1'b1;
    for (int f = 0; f < 2; f++) begin
      start_frame();
      wait_done(2000);
    end
    rand_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Frame E: reset during line 1, abandoned; frame F runs in full.
    start_frame();
    wait_line1();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check_reset_outputs("midreset");
    rst = 1'b0;
    sb.delete();
    done_before = done_cnt;
    vs_before   = vsync_cnt;
    repeat (100) @(negedge clk);
    #3;
    check("abandoned_no_done", done_cnt, done_before);
    check("idle_no_vsync", vsync_cnt, vs_before);
    exp_stall = 0;
    start_frame();
    wait_done(400);
    check("restart_vsync", vsync_cnt, vs_before + 1);
    check("underrun_after_reset", underrun, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
